// File: rtl/fetch_if.sv
// Bus between the fetch stage, instruction memory, execute (redirect) and decode.
// Handshake: imem_req is a one-cycle strobe qualifying imem_addr; imem_rvalid/imem_rdata answer it
// one or more cycles later with at most one request outstanding. On the decode side instr_valid marks
// a live instr/pc, stall is the inverse of ready, and an edge with instr_valid=1, stall=0 consumes it.
interface fetch_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  stall;
   logic                  PCsrc;
   logic [DATA_WIDTH-1:0] PCTarget;
   logic                  imem_req;
   logic [DATA_WIDTH-1:0] imem_addr;
   logic                  imem_rvalid;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic [DATA_WIDTH-1:0] instr;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic                  instr_valid;

   modport master (
      input  stall, PCsrc, PCTarget, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid
   );

   modport slave (
      output stall, PCsrc, PCTarget, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads and registers instr/pc for decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets a sticky misaligned flag and halts fetch.
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic       clk,
   input  logic       rst,
   fetch_if.master    bus,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic       misaligned,
`endif
   output logic [2:0] fsm_state
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(4);

   state_t                state;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0] pc_out_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic [DATA_WIDTH-1:0] buf_pc_q;
   logic [DATA_WIDTH-1:0] target;
   logic                  discard;
   logic                  instr_valid_q;
   logic                  free;
   logic                  trap;

   assign target = bus.PCTarget & ALIGN_MASK;
   assign free   = !instr_valid_q || !bus.stall;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign trap   = (bus.PCTarget[1:0] != 2'b00);
`else
   assign trap   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         pc_q          <= RESET_PC;
         discard       <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= NOP_INSTR;
         pc_out_q      <= RESET_PC;
         buf_q         <= '0;
         buf_pc_q      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned    <= 1'b0;
`endif
      end else if (bus.PCsrc && state != S_HALT) begin
         // Redirect beats stall and any capture; wrong-path data in flight is dropped.
         pc_q          <= target;
         instr_valid_q <= 1'b0;
         instr_q       <= NOP_INSTR;
         discard       <= 1'b0;
         if (trap) begin
            state <= S_HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= 1'b1;
`endif
         end else begin
            case (state)
               S_REQ: begin
                  discard <= 1'b1;
                  state   <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus.imem_rvalid) state   <= S_REQ;
                  else                 discard <= 1'b1;
               end
               default: state <= S_REQ;
            endcase
         end
      end else begin
         if (!bus.stall) begin
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
         end
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ:  state <= S_WAIT;
            S_WAIT: begin
               if (bus.imem_rvalid) begin
                  if (discard) begin
                     discard <= 1'b0;
                     state   <= S_REQ;
                  end else if (free) begin
                     instr_q       <= bus.imem_rdata;
                     pc_out_q      <= pc_q;
                     instr_valid_q <= 1'b1;
                     pc_q          <= pc_q + STEP;
                     state         <= S_REQ;
                  end else begin
                     // Decode is holding a live instruction: park the response.
                     buf_q    <= bus.imem_rdata;
                     buf_pc_q <= pc_q;
                     pc_q     <= pc_q + STEP;
                     state    <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!bus.stall) begin
                  instr_q       <= buf_q;
                  pc_out_q      <= buf_pc_q;
                  instr_valid_q <= 1'b1;
                  state         <= S_REQ;
               end
            end
            default: state <= state;
         endcase
      end
   end

   assign bus.imem_req    = (state == S_REQ);
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.pc          = pc_out_q;
   assign bus.pc_plus4    = pc_out_q + STEP;
   assign bus.instr_valid = instr_valid_q;
   assign fsm_state       = state;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table and corner sequences plus random stall/redirect traffic
// checked against an instruction-stream model (accepted pcs are sequential from reset or redirect target).
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] st1;
   logic [2:0] st2;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic mis1;
   logic mis2;
`endif

   fetch_if #(.DATA_WIDTH(32)) bus ();
   fetch_if #(.DATA_WIDTH(32)) bus2 ();

   fetch_stage #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .bus(bus),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misaligned(mis1),
`endif
      .fsm_state(st1)
   );

   fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misaligned(mis2),
`endif
      .fsm_state(st2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_accept = 0;
   int lat      = 1;
   int pend     = 0;
   int pend2    = 0;
   logic [31:0] pend_addr;
   logic [31:0] pend2_addr;
   logic [31:0] exp_q[$];
   logic [31:0] addr2_q[$];
   logic [31:0] pc2_q[$];
   logic [31:0] instr2_q[$];
   logic        outstanding;
   logic        hold_chk;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h100 + (a >> 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Instruction memories: respond lat cycles after a request strobe.
   always @(posedge clk) begin
      #2;
      if (rst) begin
         pend = 0;
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end else begin
         bus.imem_rvalid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = word(pend_addr);
            end
         end
         if (bus.imem_req) begin
            pend      = lat;
            pend_addr = bus.imem_addr;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (rst) begin
         pend2 = 0;
         bus2.imem_rvalid = 1'b0;
         bus2.imem_rdata  = '0;
      end else begin
         bus2.imem_rvalid = 1'b0;
         if (pend2 > 0) begin
            pend2--;
            if (pend2 == 0) begin
               bus2.imem_rvalid = 1'b1;
               bus2.imem_rdata  = word(pend2_addr);
            end
         end
         if (bus2.imem_req) begin
            pend2      = 1;
            pend2_addr = bus2.imem_addr;
         end
      end
   end

   // Scoreboard: inputs seen at a negedge are those the next rising edge will sample.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) begin
         exp_q.delete();
         exp_q.push_back(32'h0);
         outstanding = 1'b0;
         hold_chk    = 1'b0;
      end else begin
         if (bus.imem_rvalid) outstanding = 1'b0;
         if (bus.imem_req) begin
            check("single_outstanding", {31'b0, outstanding}, 32'd0);
            outstanding = 1'b1;
         end
         if (!bus.instr_valid) check("bubble_nop", bus.instr, NOP);
         if (hold_chk) begin
            check("stall_hold_valid", {31'b0, bus.instr_valid}, 32'd1);
            check("stall_hold_pc", bus.pc, hold_pc);
            check("stall_hold_instr", bus.instr, hold_instr);
         end
         hold_chk   = bus.stall && !bus.PCsrc && bus.instr_valid;
         hold_pc    = bus.pc;
         hold_instr = bus.instr;
         if (bus.PCsrc) begin
            exp_q.delete();
            exp_q.push_back(bus.PCTarget & ~32'd3);
         end else if (bus.instr_valid && !bus.stall) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("accept_pc", bus.pc, e);
            check("accept_instr", bus.instr, word(e));
            check("accept_pc_plus4", bus.pc_plus4, e + 32'd4);
            exp_q.push_back(e + 32'd4);
            n_accept++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus2.imem_req && addr2_q.size() < 2) addr2_q.push_back(bus2.imem_addr);
         if (bus2.instr_valid && pc2_q.size() < 2) begin
            pc2_q.push_back(bus2.pc);
            instr2_q.push_back(bus2.instr);
         end
      end
   end

   task automatic cyc(input logic s, input logic p, input logic [31:0] t);
      @(posedge clk);
      #1;
      bus.stall    = s;
      bus.PCsrc    = p;
      bus.PCTarget = t;
      @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      #1;
      lat = l;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.PCsrc = 1'b0;
      bus.PCTarget = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("rst_instr", bus.instr, NOP);
      check("rst_pc", bus.pc, 32'h0);
      check("rst_req", {31'b0, bus.imem_req}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misaligned", {31'b0, mis1}, 32'd0);
`endif
      #1 rst = 1'b0;
   endtask

   task automatic wait_until_req(input string name);
      int n = 0;
      while (!bus.imem_req && n < 40) begin
         cyc(1'b0, 1'b0, 32'h0);
         n++;
      end
      check({name, "_req_seen"}, {31'b0, bus.imem_req}, 32'd1);
   endtask

   task automatic wait_until_valid(input string name, input logic s);
      int n = 0;
      while (!bus.instr_valid && n < 40) begin
         cyc(s, 1'b0, 32'h0);
         n++;
      end
      check({name, "_valid_seen"}, {31'b0, bus.instr_valid}, 32'd1);
   endtask

   typedef struct {
      logic        stall;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t t1 [7];

   initial begin
      int n;
      int base;
      logic [31:0] tgt;
      bus2.stall = 1'b0;
      bus2.PCsrc = 1'b0;
      bus2.PCTarget = '0;

      // Cycle-by-cycle view after reset release with a 1-cycle memory; last row raises stall.
      t1[0] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
      t1[1] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
      t1[2] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h100};
      t1[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
      t1[4] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h101};
      t1[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h4, NOP};
      t1[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h102};

      do_reset(1);
      for (int i = 0; i < 7; i++) begin
         cyc(t1[i].stall, 1'b0, 32'h0);
         check($sformatf("t1_req[%0d]", i), {31'b0, bus.imem_req}, {31'b0, t1[i].req});
         if (t1[i].req) check($sformatf("t1_addr[%0d]", i), bus.imem_addr, t1[i].addr);
         check($sformatf("t1_valid[%0d]", i), {31'b0, bus.instr_valid}, {31'b0, t1[i].valid});
         check($sformatf("t1_pc[%0d]", i), bus.pc, t1[i].pc);
         check($sformatf("t1_instr[%0d]", i), bus.instr, t1[i].instr);
      end

      // Stall held across a returning response: frozen output, no requests, then no loss.
      for (int i = 0; i < 4; i++) begin
         cyc((i < 3) ? 1'b1 : 1'b0, 1'b0, 32'h0);
         check("t2_frozen_pc", bus.pc, 32'h8);
         check("t2_frozen_instr", bus.instr, 32'h102);
         check("t2_frozen_valid", {31'b0, bus.instr_valid}, 32'd1);
         check("t2_no_req", {31'b0, bus.imem_req}, 32'd0);
      end
      cyc(1'b0, 1'b0, 32'h0);
      check("t2_next_pc", bus.pc, 32'hC);
      check("t2_next_instr", bus.instr, 32'h103);
      check("t2_next_req", {31'b0, bus.imem_req}, 32'd1);
      check("t2_next_addr", bus.imem_addr, 32'h10);

      // Redirect one cycle after the request to 0x8 with a 3-cycle memory.
      do_reset(3);
      n = 0;
      while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 60) begin
         cyc(1'b0, 1'b0, 32'h0);
         n++;
      end
      check("t3_req8_seen", {31'b0, bus.imem_req}, 32'd1);
      cyc(1'b0, 1'b1, 32'h40);
      check("t3_wait_no_req", {31'b0, bus.imem_req}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      check("t3_killed_valid", {31'b0, bus.instr_valid}, 32'd0);
      wait_until_req("t3");
      check("t3_redirect_addr", bus.imem_addr, 32'h40);
      wait_until_valid("t3", 1'b0);
      check("t3_first_pc", bus.pc, 32'h40);
      check("t3_first_instr", bus.instr, word(32'h40));

      // Redirect, response and stall land on the same edge.
      do_reset(1);
      wait_until_valid("t4", 1'b1);
      check("t4_pc0", bus.pc, 32'h0);
      cyc(1'b1, 1'b1, 32'h80);
      check("t4_held_valid", {31'b0, bus.instr_valid}, 32'd1);
      cyc(1'b0, 1'b0, 32'h0);
      check("t4_valid_dropped", {31'b0, bus.instr_valid}, 32'd0);
      check("t4_instr_nop", bus.instr, NOP);
      check("t4_req", {31'b0, bus.imem_req}, 32'd1);
      check("t4_target_addr", bus.imem_addr, 32'h80);
      wait_until_valid("t4b", 1'b0);
      check("t4_first_pc", bus.pc, 32'h80);
      check("t4_first_instr", bus.instr, word(32'h80));

`ifdef FETCH_MISALIGN_TRAP_EN
      do_reset(1);
      cyc(1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'h42);
      cyc(1'b0, 1'b0, 32'h0);
      check("t6_misaligned", {31'b0, mis1}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 32'h0);
         check("t6_no_req", {31'b0, bus.imem_req}, 32'd0);
         check("t6_no_valid", {31'b0, bus.instr_valid}, 32'd0);
         check("t6_sticky", {31'b0, mis1}, 32'd1);
      end
`endif

      // Random stall/redirect traffic under varied memory latency.
      for (int r = 0; r < 3; r++) begin
         do_reset($urandom_range(1, 4));
         base = n_accept;
         for (int k = 0; k < 300; k++) begin
            tgt = 32'($urandom_range(0, 255)) << 2;
`ifndef FETCH_MISALIGN_TRAP_EN
            tgt = tgt | 32'($urandom_range(0, 3));
`endif
            cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, tgt);
         end
         cyc(1'b0, 1'b0, 32'h0);
         check("rand_progress", {31'b0, (n_accept > base + 10)}, 32'd1);
      end

      // PC wrap on the second instance, reset to the last word of the address space.
      while (addr2_q.size() < 2) addr2_q.push_back(32'hDEAD_BEEF);
      while (pc2_q.size() < 2) begin
         pc2_q.push_back(32'hDEAD_BEEF);
         instr2_q.push_back(32'hDEAD_BEEF);
      end
      check("t5_addr0", addr2_q[0], 32'hFFFF_FFFC);
      check("t5_addr1", addr2_q[1], 32'h0);
      check("t5_pc0", pc2_q[0], 32'hFFFF_FFFC);
      check("t5_instr0", instr2_q[0], word(32'hFFFF_FFFC));
      check("t5_pc1", pc2_q[1], 32'h0);
      check("t5_instr1", instr2_q[1], 32'h100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
